// File: rtl/regfile_read_unit.sv
// rtl/regfile_read_unit.sv - 31-entry register file with decoded write port and two handshaked read ports
// Register 31 has no storage; reads are registered responses with same-edge write bypass.
module regfile_read_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      WriteEnable,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [4:0]       ReadRegister1,
   input  logic [4:0]       ReadRegister2,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2,
   output logic             WriteError
);

   logic [WIDTH-1:0] regs_q [0:30];
   logic [WIDTH-1:0] rd1_q, rd1_d;
   logic [WIDTH-1:0] rd2_q, rd2_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             write_error_q;
   logic             multi_hot;
   logic             accept;

   // More than one bit set (bit 31 included) blocks the write and any bypass.
   assign multi_hot = |(WriteEnable & (WriteEnable - 32'd1));
   assign req_ready = !rsp_valid_q || rsp_ready;
   assign accept    = req_valid && req_ready;

   always_comb begin
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      rsp_valid_d = rsp_valid_q;
      if (accept) begin
         rd1_d       = '0;
         rd2_d       = '0;
         rsp_valid_d = 1'b1;
         for (int i = 0; i < 31; i++) begin
            if (ReadRegister1 == 5'(i))
               rd1_d = (!multi_hot && WriteEnable[i]) ? WriteData : regs_q[i];
            if (ReadRegister2 == 5'(i))
               rd2_d = (!multi_hot && WriteEnable[i]) ? WriteData : regs_q[i];
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 31; i++) regs_q[i] <= '0;
         rd1_q         <= '0;
         rd2_q         <= '0;
         rsp_valid_q   <= 1'b0;
         write_error_q <= 1'b0;
      end else begin
         for (int i = 0; i < 31; i++) begin
            if (!multi_hot && WriteEnable[i]) regs_q[i] <= WriteData;
         end
         rd1_q         <= rd1_d;
         rd2_q         <= rd2_d;
         rsp_valid_q   <= rsp_valid_d;
         write_error_q <= write_error_q | multi_hot;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign ReadData1  = rd1_q;
   assign ReadData2  = rd2_q;
   assign WriteError = write_error_q;

endmodule

// File: tb/tb_regfile_read_unit.sv
// tb/tb_regfile_read_unit.sv - scoreboard bench for regfile_read_unit
// A reference register array predicts each response when a request is accepted.
module tb_regfile_read_unit;
   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [31:0]   WriteEnable;
   logic [W-1:0]  WriteData;
   logic [4:0]    ReadRegister1, ReadRegister2;
   logic          req_valid, req_ready, rsp_valid, rsp_ready, WriteError;
   logic [W-1:0]  ReadData1, ReadData2;

   always #5 clk = ~clk;

   regfile_read_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .WriteEnable(WriteEnable), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .req_valid(req_valid), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteError(WriteError)
   );

   typedef struct packed {
      logic [W-1:0] d1;
      logic [W-1:0] d2;
   } rsp_t;

   int           total = 0;
   int           bad = 0;
   logic [W-1:0] mem [0:30];
   logic         werr_m;
   logic         rdy_seen;
   rsp_t         sb[$];

   function automatic logic [W-1:0] model_rd(input logic [4:0] r, input logic [31:0] we,
                                             input logic [W-1:0] wd, input logic multi);
      if (r == 5'd31) return '0;
      if (!multi && we[r]) return wd;
      return mem[r];
   endfunction

   task automatic model_reset();
      sb.delete();
      werr_m = 1'b0;
      for (int i = 0; i < 31; i++) mem[i] = '0;
   endtask

   // One clock: drive inputs, predict, take the edge, return at posedge+1.
   task automatic cycle(input logic [31:0] we, input logic [W-1:0] wd, input logic rv,
                        input logic [4:0] r1, input logic [4:0] r2, input logic rr);
      logic multi;
      logic acc;
      rsp_t e;
      WriteEnable = we; WriteData = wd; req_valid = rv;
      ReadRegister1 = r1; ReadRegister2 = r2; rsp_ready = rr;
      #1;
      rdy_seen = req_ready;
      multi = ($countones(we) > 1);
      acc = rv && ((sb.size() == 0) || rr);
      if (sb.size() > 0 && rr) void'(sb.pop_front());
      if (acc) begin
         e.d1 = model_rd(r1, we, wd, multi);
         e.d2 = model_rd(r2, we, wd, multi);
         sb.push_back(e);
      end
      if (multi) werr_m = 1'b1;
      else for (int i = 0; i < 31; i++) if (we[i]) mem[i] = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
      total++; if (WriteError !== 1'b0) begin bad++; $display("FAIL reset_werr got=%0h exp=0", WriteError); end
      model_reset();
      reset_n = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready); end
      cycle(32'd0, '0, 1'b1, 5'd0, 5'd31, 1'b0);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL first_rsp_valid got=%0h exp=1", rsp_valid); end
      total++; if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin bad++; $display("FAIL first_read got=%h/%h exp=0/0", ReadData1, ReadData2); end
      total++; if (WriteError !== 1'b0) begin bad++; $display("FAIL first_werr got=%0h exp=0", WriteError); end
   endtask

   task automatic test_write_read();
      cycle(32'd1 << 5, 64'hDEAD_BEEF_0000_0005, 1'b0, 5'd0, 5'd0, 1'b1);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL retire_rsp_valid got=%0h exp=0", rsp_valid); end
      cycle(32'd0, '0, 1'b1, 5'd5, 5'd5, 1'b1);
      total++; if (ReadData1 !== 64'hDEAD_BEEF_0000_0005 || ReadData2 !== 64'hDEAD_BEEF_0000_0005) begin bad++; $display("FAIL read5 got=%h/%h exp=deadbeef00000005", ReadData1, ReadData2); end
      cycle(32'h8000_0000, 64'h1, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'd0, '0, 1'b1, 5'd31, 5'd31, 1'b1);
      total++; if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin bad++; $display("FAIL read31 got=%h/%h exp=0/0", ReadData1, ReadData2); end
      total++; if (WriteError !== 1'b0) begin bad++; $display("FAIL bit31_werr got=%0h exp=0", WriteError); end
   endtask

   task automatic test_bypass();
      cycle(32'd1 << 7, 64'hA, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'd1 << 7, 64'hB, 1'b1, 5'd7, 5'd6, 1'b1);
      total++; if (ReadData1 !== 64'hB) begin bad++; $display("FAIL bypass got=%h exp=b", ReadData1); end
      total++; if (ReadData2 !== 64'h0 || ReadData2 !== sb[0].d2) begin bad++; $display("FAIL bypass_p2 got=%h exp=0", ReadData2); end
   endtask

   task automatic test_stall();
      cycle(32'd1 << 3, 64'h3, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'd0, '0, 1'b1, 5'd3, 5'd3, 1'b0);
      total++; if (rsp_valid !== 1'b1 || ReadData1 !== 64'h3) begin bad++; $display("FAIL stall_accept got=%0h/%h exp=1/3", rsp_valid, ReadData1); end
      for (int k = 0; k < 4; k++) begin
         cycle((k == 1) ? (32'd1 << 3) : 32'd0, 64'h33, 1'b1, 5'd3, 5'd3, 1'b0);
         total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL stall_req_ready%0d got=%0h exp=0", k, rdy_seen); end
         total++; if (rsp_valid !== 1'b1 || ReadData1 !== 64'h3 || ReadData2 !== 64'h3) begin bad++; $display("FAIL stall_hold%0d got=%0h/%h exp=1/3", k, rsp_valid, ReadData1); end
      end
      cycle(32'd0, '0, 1'b1, 5'd3, 5'd3, 1'b1);
      total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL unstall_req_ready got=%0h exp=1", rdy_seen); end
      total++; if (rsp_valid !== 1'b1 || ReadData1 !== 64'h33) begin bad++; $display("FAIL after_stall got=%0h/%h exp=1/33", rsp_valid, ReadData1); end
   endtask

   task automatic test_illegal();
      cycle(32'd1 << 0, 64'h10, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'd1 << 4, 64'h40, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'h0000_0011, 64'hF, 1'b1, 5'd0, 5'd4, 1'b1);
      total++; if (WriteError !== 1'b1) begin bad++; $display("FAIL werr_set got=%0h exp=1", WriteError); end
      total++; if (ReadData1 !== 64'h10 || ReadData2 !== 64'h40) begin bad++; $display("FAIL no_bypass got=%h/%h exp=10/40", ReadData1, ReadData2); end
      cycle(32'd0, '0, 1'b1, 5'd0, 5'd4, 1'b1);
      total++; if (ReadData1 !== 64'h10 || ReadData2 !== 64'h40) begin bad++; $display("FAIL illegal_unchanged got=%h/%h exp=10/40", ReadData1, ReadData2); end
      cycle(32'd1 << 2, 64'h22, 1'b0, 5'd0, 5'd0, 1'b1);
      cycle(32'd0, '0, 1'b1, 5'd2, 5'd2, 1'b1);
      total++; if (ReadData1 !== 64'h22) begin bad++; $display("FAIL legal_after got=%h exp=22", ReadData1); end
      total++; if (WriteError !== 1'b1) begin bad++; $display("FAIL werr_sticky got=%0h exp=1", WriteError); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) cycle(32'd1 << i, 64'd100 + 64'(i), 1'b0, 5'd0, 5'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(32'd0, '0, 1'b1, 5'(i), 5'(4 - i), 1'b1);
         total++; if (rdy_seen !== 1'b1 || rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%0h/%0h exp=1/1", i, rdy_seen, rsp_valid); end
         total++; if (sb.size() != 1 || ReadData1 !== 64'd100 + 64'(i) || ReadData2 !== sb[0].d2) begin bad++; $display("FAIL b2b_data%0d got=%h/%h exp=%h", i, ReadData1, ReadData2, 64'd100 + 64'(i)); end
      end
      reset_n = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%0h exp=0", rsp_valid); end
      total++; if (ReadData1 !== 64'd0 || WriteError !== 1'b0) begin bad++; $display("FAIL async_reset_state got=%h/%0h exp=0/0", ReadData1, WriteError); end
      model_reset();
      #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      cycle(32'd0, '0, 1'b1, 5'd3, 5'd4, 1'b1);
      total++; if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || ReadData1 !== sb[0].d1) begin bad++; $display("FAIL post_reset_read got=%h/%h exp=0/0", ReadData1, ReadData2); end
      cycle(32'd0, '0, 1'b1, 5'd0, 5'd7, 1'b1);
      total++; if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin bad++; $display("FAIL post_reset_read2 got=%h/%h exp=0/0", ReadData1, ReadData2); end
   endtask

   initial begin
      reset_n = 1'b0; WriteEnable = '0; WriteData = '0; ReadRegister1 = '0;
      ReadRegister2 = '0; req_valid = 1'b0; rsp_ready = 1'b0; rdy_seen = 1'b0;
      model_reset();
      #12;
      test_reset();
      test_write_read();
      test_bypass();
      test_stall();
      test_illegal();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_read_unit.md
# regfile_read_unit

Storage and read side of the 32-entry integer register file. It accepts the one-hot write-enable vector produced by the 5-to-32 write decoder, together with the write data, and stores the value into the selected register. It serves two read ports through a registered request/response handshake, with same-cycle write bypass. Register 31 is the zero register: it is never written and always reads as 0.

## Interface
- WIDTH, 64, data width of each register and of the read/write data buses
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- WriteEnable  in  32  one-hot (or all-zero) write select from the write decoder; bit 31 ignored
- WriteData  in  WIDTH  data written to the selected register
- ReadRegister1  in  5  read port 1 register index
- ReadRegister2  in  5  read port 2 register index
- req_valid  in  1  read request present on ReadRegister1/2
- req_ready  out  1  unit can accept a request this cycle
- rsp_valid  out  1  ReadData1/2 hold a valid response
- rsp_ready  in  1  consumer takes the response this cycle
- ReadData1  out  WIDTH  response data for port 1
- ReadData2  out  WIDTH  response data for port 2
- WriteError  out  1  sticky flag, set when WriteEnable has more than one bit set

## Operation
- Storage: 31 registers (indices 0–30) of WIDTH bits. Index 31 has no storage and reads as 0.
- Write:
  - If WriteEnable has exactly one bit set at bit i < 31, register i loads WriteData on the clock edge.
  - If WriteEnable is all-zero, or has only bit 31 set, nothing is written.
  - If two or more bits are set (bit 31 is counted), no register is written and WriteError is set. WriteError stays high until reset.
- Request acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready = !rsp_valid || rsp_ready, combinational.
  - On acceptance, ReadData1/2 are loaded and rsp_valid is set.
- Data selection per port, for the accepted index r:
  - r = 31 → 0.
  - Otherwise, if a legal write to r occurs on the same edge → WriteData (bypass).
  - Otherwise → stored value of r.
  - An illegal write (WriteError condition) never bypasses.
- Response hold:
  - While rsp_valid && !rsp_ready, ReadData1/2 and rsp_valid are frozen.
  - The response is a snapshot: later writes to the same register do not alter a pending response.
- Response retire:
  - When rsp_valid && rsp_ready and no new request is accepted, rsp_valid clears.
  - ReadData1/2 keep their last value while rsp_valid is 0.
- Both ports may name the same register, and both return identical data.
- Writes proceed every cycle, independent of the read handshake state.

## Timing
- Reset (reset_n low, asynchronous): all registers, ReadData1/2, rsp_valid and WriteError go to 0 immediately, with no clock required.
- After reset_n rises, req_ready = 1.
- Read latency: a request accepted at edge N gives rsp_valid = 1 and data valid right after edge N, i.e. one cycle.
- Throughput: one request per cycle when rsp_ready is held high (back-to-back: retire and accept on the same edge).
- Write visibility:
  - A write at edge N is returned by a request accepted at edge N (bypass).
  - It is also returned by any request accepted at a later edge.
  - It is not reflected in a response already pending before edge N.
- Reset mid-operation: a pending response is discarded. rsp_valid drops asynchronously and the first post-reset request reads 0 from every register.
- No combinational path from req_valid or ReadRegister1/2 to ReadData1/2. The only combinational output path is rsp_ready → req_ready.

## Test plan
- Reset then read: pulse reset_n low, then request (0, 31) → next cycle rsp_valid = 1, ReadData1 = 0, ReadData2 = 0, WriteError = 0.
- Write then read:
  - Write 64'hDEAD_BEEF_0000_0005 with WriteEnable = 1<<5.
  - Next cycle, request (5, 5) → both ReadData = 64'hDEAD_BEEF_0000_0005.
  - Write 64'h1 with WriteEnable = 1<<31, then read 31 → 0.
- Bypass:
  - Register 7 holds 64'hA.
  - On the same edge, write 64'hB to register 7 and accept request (7, 6) → ReadData1 = 64'hB.
- Stall and snapshot:
  - Accept a read of register 3 (value 64'h3) with rsp_ready = 0 for 4 cycles, and write 64'h33 to register 3 during the stall.
  - Required: req_ready = 0, ReadData1 = 64'h3 held, rsp_valid stays 1. After rsp_ready = 1, a new read of register 3 → 64'h33.
- Illegal write: WriteEnable = 32'h0000_0011 with WriteData = 64'hF → registers 0 and 4 unchanged, WriteError = 1 and sticky. The next legal write succeeds.
- Back-to-back with reset: with rsp_ready = 1, issue 5 consecutive requests (0..4), one per cycle → 5 responses in consecutive cycles. Assert reset_n low mid-stream → rsp_valid = 0 immediately, and all later reads return 0.
